// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer.
// Outputs come only from the main (head) register. in_ready is a dedicated flop.
module ex_mem_skid_reg #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RW   = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result_e,
    input  logic [XLEN-1:0] write_data_e,
    input  logic [RW-1:0]   rd_e,
    input  logic            reg_write_e,
    input  logic [XLEN-1:0] pc_plus4_e,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [RW-1:0]   rd_m,
    output logic            reg_write_m,
    output logic [XLEN-1:0] pc_plus4_m,
    output logic [RW-1:0]   fwd_rd
);

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [RW-1:0]   rd;
        logic            reg_write;
        logic [XLEN-1:0] pc_plus4;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t state_q, state_d;
    beat_t  main_q, main_d;
    beat_t  skid_q, skid_d;
    beat_t  in_beat;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   in_xfer;
    logic   out_xfer;

    always_comb begin
        in_beat.alu_result = alu_result_e;
        in_beat.write_data = write_data_e;
        in_beat.rd         = rd_e;
        in_beat.reg_write  = reg_write_e;
        in_beat.pc_plus4   = pc_plus4_e;
    end

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = main_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush only retires beats; data registers keep their contents.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_d  = in_beat;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_beat;
                    end else if (in_xfer) begin
                        skid_d  = in_beat;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        main_valid_d = (state_d != EMPTY);
        skid_valid_d = (state_d == FULL);
        in_ready_d   = !skid_valid_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_valid_q;
    assign alu_result_m = main_q.alu_result;
    assign write_data_m = main_q.write_data;
    assign rd_m         = main_q.rd;
    assign reg_write_m  = main_q.reg_write;
    assign pc_plus4_m   = main_q.pc_plus4;
    assign fwd_rd       = (main_valid_q && main_q.reg_write) ? main_q.rd : '0;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg (XLEN=64): the reference is a depth-2 FIFO queue.
module tb_ex_mem_skid_reg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RW   = 5;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic [63:0] pc;
    } beat_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] alu_result_e = '0;
    logic [XLEN-1:0] write_data_e = '0;
    logic [RW-1:0]   rd_e = '0;
    logic            reg_write_e = 1'b0;
    logic [XLEN-1:0] pc_plus4_e = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] alu_result_m;
    logic [XLEN-1:0] write_data_m;
    logic [RW-1:0]   rd_m;
    logic            reg_write_m;
    logic [XLEN-1:0] pc_plus4_m;
    logic [RW-1:0]   fwd_rd;

    int    vectors = 0;
    int    miscompares = 0;
    bit    done = 1'b0;
    beat_t exp_q[$];

    ex_mem_skid_reg #(.XLEN(XLEN), .RW(RW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e),
        .rd_e(rd_e), .reg_write_e(reg_write_e), .pc_plus4_e(pc_plus4_e),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .pc_plus4_m(pc_plus4_m),
        .fwd_rd(fwd_rd)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired, got %0d vectors, required finish", vectors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [63:0] alu, input logic [4:0] rd, input logic rw);
        beat_t b;
        b.alu = alu;
        b.wd  = {$urandom(), $urandom()};
        b.rd  = rd;
        b.rw  = rw;
        b.pc  = {$urandom(), $urandom()};
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        return mk({$urandom(), $urandom()}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    endfunction

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic cycle(input logic v, input beat_t b, input logic fl, input logic ordy);
        bit acc;
        @(negedge clock);
        in_valid     = v;
        alu_result_e = b.alu;
        write_data_e = b.wd;
        rd_e         = b.rd;
        reg_write_e  = b.rw;
        pc_plus4_e   = b.pc;
        flush        = fl;
        out_ready    = ordy;
        acc = v && !fl && (exp_q.size() < 2);
        @(posedge clock);
        #1;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(b);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, mk(64'h0, 5'd0, 1'b0), 1'b0, ordy);
    endtask

    // Monitor: one tick before each rising edge, compare the head and pop on handshake.
    initial begin
        forever begin
            @(negedge clock);
            #4;
            if (!reset && !done) begin
                chk("out_valid", {63'b0, out_valid}, {63'b0, exp_q.size() > 0});
                chk("in_ready", {63'b0, in_ready}, {63'b0, exp_q.size() < 2});
                if (exp_q.size() > 0) begin
                    chk("alu_result_m", alu_result_m, exp_q[0].alu);
                    chk("write_data_m", write_data_m, exp_q[0].wd);
                    chk("rd_m", {59'b0, rd_m}, {59'b0, exp_q[0].rd});
                    chk("reg_write_m", {63'b0, reg_write_m}, {63'b0, exp_q[0].rw});
                    chk("pc_plus4_m", pc_plus4_m, exp_q[0].pc);
                    chk("fwd_rd", {59'b0, fwd_rd}, exp_q[0].rw ? {59'b0, exp_q[0].rd} : 64'h0);
                    if (out_ready) void'(exp_q.pop_front());
                end else begin
                    chk("fwd_rd_empty", {59'b0, fwd_rd}, 64'h0);
                end
            end
        end
    end

    initial begin
        // Reset state while reset is held.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'h1);
        chk("rst_alu", alu_result_m, 64'h0);
        chk("rst_pc", pc_plus4_m, 64'h0);
        chk("rst_fwd", {59'b0, fwd_rd}, 64'h0);
        @(negedge clock);
        reset = 1'b0;

        // Streaming at full throughput.
        cycle(1'b1, mk(64'h10, 5'd1, 1'b1), 1'b0, 1'b1);
        chk("stream_lat", alu_result_m, 64'h10);
        cycle(1'b1, mk(64'h20, 5'd2, 1'b1), 1'b0, 1'b1);
        chk("stream_b", alu_result_m, 64'h20);
        cycle(1'b1, mk(64'h30, 5'd3, 1'b1), 1'b0, 1'b1);
        chk("stream_c", alu_result_m, 64'h30);
        chk("stream_rdy", {63'b0, in_ready}, 64'h1);
        idle(1'b1);

        // Backpressure fills the skid; C is offered but refused.
        cycle(1'b1, mk(64'h11, 5'd4, 1'b1), 1'b0, 1'b0);
        cycle(1'b1, mk(64'h22, 5'd5, 1'b0), 1'b0, 1'b0);
        chk("bp_full_rdy", {63'b0, in_ready}, 64'h0);
        chk("bp_hold_a", alu_result_m, 64'h11);
        cycle(1'b1, mk(64'h33, 5'd6, 1'b1), 1'b0, 1'b0);
        chk("bp_still_a", alu_result_m, 64'h11);
        cycle(1'b0, mk(64'h0, 5'd0, 1'b0), 1'b0, 1'b1);
        chk("bp_b", alu_result_m, 64'h22);
        cycle(1'b1, mk(64'h33, 5'd6, 1'b1), 1'b0, 1'b1);
        chk("bp_c", alu_result_m, 64'h33);
        idle(1'b1);

        // Flush while full with a beat offered in the flush cycle.
        cycle(1'b1, mk(64'h55, 5'd7, 1'b1), 1'b0, 1'b0);
        cycle(1'b1, mk(64'h66, 5'd8, 1'b1), 1'b0, 1'b0);
        chk("fwd_rd7", {59'b0, fwd_rd}, 64'h7);
        cycle(1'b1, mk(64'h44, 5'd9, 1'b1), 1'b1, 1'b0);
        chk("flush_valid", {63'b0, out_valid}, 64'h0);
        chk("flush_rdy", {63'b0, in_ready}, 64'h1);
        chk("flush_fwd", {59'b0, fwd_rd}, 64'h0);
        chk("flush_keep_data", alu_result_m, 64'h55);
        idle(1'b0);
        chk("flush_drop44", {63'b0, out_valid}, 64'h0);

        // fwd_rd gated by reg_write.
        cycle(1'b1, mk(64'h77, 5'd7, 1'b0), 1'b0, 1'b0);
        chk("fwd_rd_nowr", {59'b0, fwd_rd}, 64'h0);
        idle(1'b1);

        // Async reset pulsed between edges while full.
        cycle(1'b1, mk(64'h88, 5'd10, 1'b1), 1'b0, 1'b0);
        cycle(1'b1, mk(64'h99, 5'd11, 1'b1), 1'b0, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_valid", {63'b0, out_valid}, 64'h0);
        chk("arst_rdy", {63'b0, in_ready}, 64'h1);
        chk("arst_alu", alu_result_m, 64'h0);
        chk("arst_fwd", {59'b0, fwd_rd}, 64'h0);
        reset = 1'b0;
        exp_q.delete();

        // Wide datapath, then randomized traffic.
        cycle(1'b1, mk(64'hFFFF_FFFF_0000_0001, 5'd12, 1'b1), 1'b0, 1'b0);
        chk("xlen64", alu_result_m, 64'hFFFF_FFFF_0000_0001);
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rnd_beat(),
                  1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 9) < 6));
        end
        repeat (3) idle(1'b1);
        chk("drain_empty", {63'b0, out_valid}, 64'h0);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface

Parameters, one per line (name, default, meaning):
- REQ-001 XLEN, 32, data path width in bits; SHALL be supported for any value from 32 to 64.
- REQ-002 RW, 5, register index width in bits.

Ports, one per line (name, direction, width, meaning):
- REQ-003 clock, input, 1, single clock; all state SHALL update on its rising edge.
- REQ-004 reset, input, 1, asynchronous, active-high reset.
- REQ-005 flush, input, 1, synchronous kill of all held beats.
- REQ-006 in_valid, input, 1, EX stage presents a beat.
- REQ-007 in_ready, output, 1, stage can accept a beat; driven directly from a flop.
- REQ-008 alu_result_e, input, XLEN, ALU result.
- REQ-009 write_data_e, input, XLEN, store data.
- REQ-010 rd_e, input, RW, destination register index.
- REQ-011 reg_write_e, input, 1, destination write enable.
- REQ-012 pc_plus4_e, input, XLEN, PC+4.
- REQ-013 out_valid, output, 1, MEM-side beat valid.
- REQ-014 out_ready, input, 1, MEM stage accepts the beat.
- REQ-015 alu_result_m, write_data_m, rd_m, reg_write_m, pc_plus4_m, outputs, matching widths, head-beat fields.
- REQ-016 fwd_rd, output, RW, rd_m when out_valid and reg_write_m are both 1, else 0 (combinational).

Function

- REQ-017 Storage SHALL consist of a main register (head) and a skid register, each holding all five fields plus a valid bit.
- REQ-018 Every field output and out_valid SHALL come from the main register only.
- REQ-019 in_ready SHALL equal NOT(skid valid).
- REQ-020 Handshakes: an input transfer occurs on in_valid and in_ready; an output transfer occurs on out_valid and out_ready.
- REQ-021 States: EMPTY (main invalid, skid invalid), ONE (main valid, skid invalid), FULL (both valid).
- REQ-022 EMPTY: in_valid -> load main, go to ONE; otherwise stay in EMPTY.
- REQ-023 ONE, input and output transfer in the same cycle -> main takes the new beat, stay in ONE.
- REQ-024 ONE, input transfer only -> skid takes the new beat, go to FULL.
- REQ-025 ONE, output transfer only -> go to EMPTY.
- REQ-026 ONE, neither transfer -> hold.
- REQ-027 FULL: in_ready=0 and in_valid is ignored.
- REQ-028 FULL, out_ready -> main takes the skid beat, go to ONE; otherwise hold.
- REQ-029 Latency: a beat accepted in EMPTY SHALL appear on the outputs in the next cycle.
- REQ-030 Throughput: one beat per cycle while out_ready=1.
- REQ-031 Ordering: beats SHALL leave in acceptance order; no beat is dropped or duplicated except by flush or reset.
- REQ-032 Held fields SHALL not change while out_valid=1 and out_ready=0.
- REQ-033 Flush SHALL clear both valid bits and go to EMPTY at the next edge.
- REQ-034 A beat offered during the flush cycle SHALL be discarded, even if in_ready=1.
- REQ-035 Flush SHALL leave data fields unchanged.
- REQ-036 Priority: reset over flush over handshake.
- REQ-037 When flush and out_ready are both 1, the head beat SHALL count as consumed; the MEM side samples it that cycle.
- REQ-038 in_ready SHALL be 1 in the cycle after a flush.

Reset

- REQ-039 Asserting reset SHALL immediately clear both valid bits and zero every data field of both registers, independent of clock.
- REQ-040 While reset=1: out_valid=0, in_ready=1, all field outputs 0, fwd_rd=0.
- REQ-041 Reset asserted mid-transfer SHALL discard all held beats.
- REQ-042 The first edge after reset deassertion SHALL behave as the EMPTY state.

Verification

- REQ-043 Streaming: out_ready=1, beats alu_result 0x10, 0x20, 0x30 on consecutive cycles -> outputs 0x10, 0x20, 0x30 one cycle later each; in_ready stays 1.
- REQ-044 Backpressure: out_ready=0, beats A=0x11, B=0x22, C=0x33 offered -> A held on outputs, B in skid, in_ready=0, C not accepted; then out_ready=1 -> A, B, C delivered in order.
- REQ-045 Flush while FULL: flush=1 with in_valid=1 (beat 0x44) -> next cycle out_valid=0, in_ready=1, 0x44 never appears.
- REQ-046 fwd_rd: head rd=7 with reg_write=1 -> fwd_rd=7; with reg_write=0 -> 0; after flush -> 0.
- REQ-047 Async reset: reset pulsed between edges while FULL -> out_valid=0 and fields 0 before the next edge; in_ready=1.
- REQ-048 XLEN=64: beat with alu_result 0xFFFF_FFFF_0000_0001 -> output matches bit-exact.
